// File: rtl/bank_rd_arbiter.sv
// Per-bank round-robin read arbiter: shares single-read-port register-file banks
// among CPU read ports and steers the returned bank data back one cycle later.
module bank_rd_arbiter #(
    parameter int NUM_BANKS     = 3,
    parameter int SIZE_BANKI    = 32,
    parameter int NUM_RD_PORTS  = 3,
    parameter int DATA_W        = 32,
    parameter int SHIRINA_BANKI = $clog2(SIZE_BANKI),
    parameter int BANK_W        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_RD_PORTS-1:0]                     rd_req,
    input  logic [NUM_RD_PORTS-1:0][BANK_W-1:0]         rd_bank,
    input  logic [NUM_RD_PORTS-1:0][SHIRINA_BANKI-1:0]  ra,
    output logic [NUM_RD_PORTS-1:0]                     rd_ack,
    output logic [NUM_RD_PORTS-1:0]                     rd_vld,
    output logic [NUM_RD_PORTS-1:0]                     rd_err,
    output logic [NUM_RD_PORTS-1:0][DATA_W-1:0]         rd_data,
    output logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0]      bank_gnt,
    output logic [NUM_BANKS-1:0]                        bank_re,
    output logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0]     bank_ra,
    input  logic [NUM_BANKS-1:0][DATA_W-1:0]            bank_rdata
);

    localparam int PORT_W = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1;

    logic [NUM_BANKS-1:0][PORT_W-1:0]       ptr_r;
    logic [NUM_BANKS-1:0][PORT_W-1:0]       win_s;
    logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0] gnt_s;
    logic [NUM_RD_PORTS-1:0]                oor_s;
    logic [NUM_RD_PORTS-1:0]                vld_r;
    logic [NUM_RD_PORTS-1:0]                err_r;
    logic [NUM_RD_PORTS-1:0][BANK_W-1:0]    bank_r;

    // Round-robin search per bank starting after the last granted port; flag out-of-range banks
    always_comb begin
        logic found_s;
        int   idx_s;
        gnt_s   = '0;
        win_s   = ptr_r;
        oor_s   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (rd_req[p] && (int'(rd_bank[p]) >= NUM_BANKS)) begin
                oor_s[p] = 1'b1;
            end else begin
                oor_s[p] = 1'b0;
            end
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            found_s = 1'b0;
            for (int k = 1; k <= NUM_RD_PORTS; k++) begin
                idx_s = (int'(ptr_r[b]) + k) % NUM_RD_PORTS;
                if (!found_s && rd_req[idx_s] && (int'(rd_bank[idx_s]) == b)) begin
                    found_s          = 1'b1;
                    gnt_s[b][idx_s]  = 1'b1;
                    win_s[b]         = PORT_W'(idx_s);
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Bank-side and ack outputs, all forced idle while reset is held
    always_comb begin
        rd_ack   = '0;
        bank_gnt = '0;
        bank_re  = '0;
        bank_ra  = '0;
        if (rst) begin
            rd_ack   = '0;
            bank_gnt = '0;
        end else begin
            bank_gnt = gnt_s;
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_re[b] = |gnt_s[b];
                for (int p = 0; p < NUM_RD_PORTS; p++) begin
                    bank_ra[b] = bank_ra[b] | (ra[p] & {SHIRINA_BANKI{gnt_s[b][p]}});
                    rd_ack[p]  = rd_ack[p] | gnt_s[b][p];
                end
            end
            rd_ack = rd_ack | oor_s;
        end
    end

    // Return path: registered valid/error steer the bank's data; a reset cycle hides in-flight reads
    always_comb begin
        rd_vld  = '0;
        rd_err  = '0;
        rd_data = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_vld[p] = vld_r[p] & ~rst;
            rd_err[p] = vld_r[p] & err_r[p] & ~rst;
            if (vld_r[p] && !err_r[p] && !rst && (int'(bank_r[p]) < NUM_BANKS)) begin
                rd_data[p] = bank_rdata[bank_r[p]];
            end else begin
                rd_data[p] = '0;
            end
        end
    end

    // Round-robin pointers and per-port read-return tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                ptr_r[b] <= PORT_W'(NUM_RD_PORTS - 1);
            end
            vld_r  <= '0;
            err_r  <= '0;
            bank_r <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (|gnt_s[b]) begin
                    ptr_r[b] <= win_s[b];
                end
            end
            vld_r <= rd_ack;
            err_r <= oor_s & rd_ack;
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                if (rd_ack[p]) begin
                    bank_r[p] <= rd_bank[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_bank_rd_arbiter.sv
// Directed bench for bank_rd_arbiter: stimulus pushes expected read returns into
// per-port queues; a negedge monitor pops and compares whenever rd_vld is seen.
module tb_bank_rd_arbiter;

    localparam int NB = 3;
    localparam int NP = 3;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int BW = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NP-1:0]            rd_req;
    logic [NP-1:0][BW-1:0]    rd_bank;
    logic [NP-1:0][AW-1:0]    ra;
    logic [NP-1:0]            rd_ack;
    logic [NP-1:0]            rd_vld;
    logic [NP-1:0]            rd_err;
    logic [NP-1:0][DW-1:0]    rd_data;
    logic [NB-1:0][NP-1:0]    bank_gnt;
    logic [NB-1:0]            bank_re;
    logic [NB-1:0][AW-1:0]    bank_ra;
    logic [NB-1:0][DW-1:0]    bank_rdata = '0;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [DW:0] exp_q [NP][$];

    always #5 clk = ~clk;

    bank_rd_arbiter #(
        .NUM_BANKS(NB), .SIZE_BANKI(32), .NUM_RD_PORTS(NP), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_bank(rd_bank), .ra(ra),
        .rd_ack(rd_ack), .rd_vld(rd_vld), .rd_err(rd_err), .rd_data(rd_data),
        .bank_gnt(bank_gnt), .bank_re(bank_re), .bank_ra(bank_ra),
        .bank_rdata(bank_rdata)
    );

    // Bank array model: bank b returns (b << 8) + address one cycle after a read
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_re[b]) bank_rdata[b] <= (DW'(b) << 8) + DW'(bank_ra[b]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every valid return must match the oldest expected entry for that port
    always @(negedge clk) begin
        logic [DW:0] e;
        for (int p = 0; p < NP; p++) begin
            if (rd_vld[p] === 1'b1) begin
                if (exp_q[p].size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_vld port %0d: got rd_vld=1, expected no return", p);
                end else begin
                    e = exp_q[p].pop_front();
                    chk($sformatf("rd_err[%0d]", p), 32'(rd_err[p]), 32'(e[DW]));
                    chk($sformatf("rd_data[%0d]", p), rd_data[p], e[DW-1:0]);
                end
            end else begin
                chk($sformatf("idle_err[%0d]", p), 32'(rd_err[p]), 32'd0);
                chk($sformatf("idle_data[%0d]", p), rd_data[p], 32'd0);
            end
        end
    end

    task automatic step(input string name, input logic rst_v, input logic [2:0] req,
                        input logic [5:0] banks, input logic [14:0] ras,
                        input logic [2:0] e_ack, input logic [2:0] e_re,
                        input logic [8:0] e_gnt, input logic [14:0] e_ra,
                        input logic [2:0] push, input logic [2:0] e_err,
                        input logic [95:0] e_data);
        rst     = rst_v;
        rd_req  = req;
        rd_bank = banks;
        ra      = ras;
        #2;
        chk({name, " ack"}, 32'(rd_ack), 32'(e_ack));
        chk({name, " re"}, 32'(bank_re), 32'(e_re));
        chk({name, " gnt"}, 32'(bank_gnt), 32'(e_gnt));
        chk({name, " bank_ra"}, 32'(bank_ra), 32'(e_ra));
        for (int p = 0; p < NP; p++) begin
            if (push[p]) exp_q[p].push_back({e_err[p], e_data[p*32 +: 32]});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        rd_req  = '0;
        rd_bank = '0;
        ra      = '0;
        @(posedge clk);
        #1;
        // Requests during reset are ignored
        step("rst_req", 1'b1, 3'b111, {2'd1, 2'd1, 2'd1}, {5'd7, 5'd6, 5'd5},
             3'b000, 3'b000, 9'd0, 15'd0, 3'b000, 3'b000, 96'd0);
        step("rst_idle", 1'b1, 3'b000, 6'd0, 15'd0, 3'b000, 3'b000, 9'd0, 15'd0, 3'b000, 3'b000, 96'd0);
        for (int i = 0; i < 5; i++)
            step("idle", 1'b0, 3'b000, 6'd0, 15'd0, 3'b000, 3'b000, 9'd0, 15'd0, 3'b000, 3'b000, 96'd0);
        // Three ports hammer bank 1: grants rotate 0,1,2,0,1,2
        for (int i = 0; i < 6; i++) begin
            int p;
            p = i % 3;
            step("rr_bank1", 1'b0, 3'b111, {2'd1, 2'd1, 2'd1}, {5'd7, 5'd6, 5'd5},
                 3'(1 << p), 3'b010, 9'(1 << (p + 3)), {5'd0, 5'(5 + p), 5'd0},
                 3'(1 << p), 3'b000, 96'(32'h105 + p) << (32 * p));
        end
        // Each port on its own bank: all granted together
        step("parallel", 1'b0, 3'b111, {2'd2, 2'd1, 2'd0}, {5'd9, 5'd4, 5'd3},
             3'b111, 3'b111, 9'b100_010_001, {5'd9, 5'd4, 5'd3},
             3'b111, 3'b000, {32'h209, 32'h104, 32'h003});
        // Out-of-range bank on port 2
        step("oor_bank", 1'b0, 3'b100, {2'd3, 2'd0, 2'd0}, 15'd0,
             3'b100, 3'b000, 9'd0, 15'd0, 3'b100, 3'b100, 96'd0);
        // Pointer after port 1 wins bank 0 favours port 2 over port 0
        step("p1_bank0", 1'b0, 3'b010, 6'd0, {5'd0, 5'd1, 5'd0},
             3'b010, 3'b001, 9'b000_000_010, {10'd0, 5'd1},
             3'b010, 3'b000, {32'd0, 32'h001, 32'd0});
        step("p2_first", 1'b0, 3'b101, 6'd0, {5'd8, 5'd0, 5'd2},
             3'b100, 3'b001, 9'b000_000_100, {10'd0, 5'd8},
             3'b100, 3'b000, {32'h008, 64'd0});
        step("p0_next", 1'b0, 3'b101, 6'd0, {5'd8, 5'd0, 5'd2},
             3'b001, 3'b001, 9'b000_000_001, {10'd0, 5'd2},
             3'b001, 3'b000, {64'd0, 32'h002});
        // Ack followed by reset: that return must never appear
        step("pre_rst", 1'b0, 3'b010, 6'd0, {5'd0, 5'd10, 5'd0},
             3'b010, 3'b001, 9'b000_000_010, {10'd0, 5'd10},
             3'b000, 3'b000, 96'd0);
        step("rst_mid", 1'b1, 3'b011, 6'd0, {5'd0, 5'd12, 5'd11},
             3'b000, 3'b000, 9'd0, 15'd0, 3'b000, 3'b000, 96'd0);
        step("post_rst0", 1'b0, 3'b011, 6'd0, {5'd0, 5'd12, 5'd11},
             3'b001, 3'b001, 9'b000_000_001, {10'd0, 5'd11},
             3'b001, 3'b000, {64'd0, 32'h00b});
        step("post_rst1", 1'b0, 3'b011, 6'd0, {5'd0, 5'd12, 5'd11},
             3'b010, 3'b001, 9'b000_000_010, {10'd0, 5'd12},
             3'b010, 3'b000, {32'd0, 32'h00c, 32'd0});
        for (int i = 0; i < 3; i++)
            step("drain", 1'b0, 3'b000, 6'd0, 15'd0, 3'b000, 3'b000, 9'd0, 15'd0, 3'b000, 3'b000, 96'd0);
        for (int p = 0; p < NP; p++)
            chk($sformatf("pending_returns[%0d]", p), 32'(exp_q[p].size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
